// File: rtl/dcache_mem_req_sched.sv
// Arbitrates the write-through dcache memory request port between loads and the write buffer,
// enforcing the store credit limit, the load ID pool and ordering of non-cacheable loads.
module dcache_mem_req_sched #(
    parameter int unsigned AddrWidth            = 32,
    parameter int unsigned DataWidth            = 32,
    parameter int unsigned NrLoadIds            = 2,
    parameter int unsigned MaxOutstandingStores = 7,
    parameter int unsigned StarveLimit          = 4,
    localparam int unsigned TidWidth   = (NrLoadIds > 1) ? $clog2(NrLoadIds) : 1,
    localparam int unsigned StCntWidth = $clog2(MaxOutstandingStores + 1),
    localparam int unsigned BeWidth    = DataWidth / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ld_req_i,
    output logic                  ld_gnt_o,
    input  logic [AddrWidth-1:0]  ld_addr_i,
    input  logic                  ld_nc_i,
    output logic [TidWidth-1:0]   ld_tid_o,
    input  logic                  st_req_i,
    output logic                  st_gnt_o,
    input  logic [AddrWidth-1:0]  st_addr_i,
    input  logic [DataWidth-1:0]  st_data_i,
    input  logic [BeWidth-1:0]    st_be_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [AddrWidth-1:0]  mem_addr_o,
    output logic [DataWidth-1:0]  mem_wdata_o,
    output logic [BeWidth-1:0]    mem_be_o,
    output logic [TidWidth-1:0]   mem_tid_o,
    input  logic                  mem_rsp_valid_i,
    input  logic                  mem_rsp_we_i,
    input  logic [TidWidth-1:0]   mem_rsp_tid_i,
    output logic [StCntWidth-1:0] st_outstanding_o,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int unsigned StarveWidth = $clog2(StarveLimit + 1);

    logic [NrLoadIds-1:0]   id_busy_q, id_busy_d;
    logic [StCntWidth-1:0]  st_cnt_q, st_cnt_d;
    logic [StarveWidth-1:0] starve_q, starve_d;
    logic                   err_q, err_d;

    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [BeWidth-1:0]     be_q, be_d;
    logic [TidWidth-1:0]    tid_q, tid_d;

    logic                   id_free;
    logic [TidWidth-1:0]    free_id;
    logic                   reg_free, ld_elig, st_elig, st_win, ld_gnt, st_gnt;
    logic                   rsp_ld, rsp_st, st_inc, st_dec;

    // Lowest free ID wins; the scan runs high-to-low so the last hit is the lowest index.
    always_comb begin
        id_free = 1'b0;
        free_id = '0;
        for (int i = NrLoadIds - 1; i >= 0; i--) begin
            if (!id_busy_q[i]) begin
                id_free = 1'b1;
                free_id = TidWidth'(unsigned'(i));
            end
        end
    end

    assign reg_free = !req_q || mem_gnt_i;
    assign ld_elig  = ld_req_i && id_free &&
                      (!ld_nc_i || (st_cnt_q == '0 && !(req_q && we_q)));
    assign st_elig  = st_req_i && (st_cnt_q < StCntWidth'(MaxOutstandingStores));
    assign st_win   = st_elig && (!ld_elig || starve_q == StarveWidth'(StarveLimit));
    assign st_gnt   = rst_ni && reg_free && st_win;
    assign ld_gnt   = rst_ni && reg_free && ld_elig && !st_win;

    assign rsp_ld = mem_rsp_valid_i && !mem_rsp_we_i;
    assign rsp_st = mem_rsp_valid_i && mem_rsp_we_i;
    assign st_inc = st_gnt;
    assign st_dec = rsp_st && (st_cnt_q != '0);

    always_comb begin
        id_busy_d = id_busy_q;
        err_d     = err_q;
        st_cnt_d  = st_cnt_q;
        starve_d  = starve_q;

        // A freed ID only shows up in the scan from the next cycle, since the scan reads _q.
        if (rsp_ld) begin
            if ((32'(mem_rsp_tid_i) < NrLoadIds) && id_busy_q[mem_rsp_tid_i]) begin
                id_busy_d[mem_rsp_tid_i] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (ld_gnt) begin
            id_busy_d[free_id] = 1'b1;
        end

        if (rsp_st && st_cnt_q == '0) begin
            err_d = 1'b1;
        end
        if (st_inc && !st_dec) begin
            st_cnt_d = st_cnt_q + StCntWidth'(1);
        end else if (st_dec && !st_inc) begin
            st_cnt_d = st_cnt_q - StCntWidth'(1);
        end

        if (st_gnt) begin
            starve_d = '0;
        end else if (st_elig && ld_gnt && starve_q != StarveWidth'(StarveLimit)) begin
            starve_d = starve_q + StarveWidth'(1);
        end
    end

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        tid_d   = tid_q;
        if (ld_gnt || st_gnt) begin
            req_d   = 1'b1;
            we_d    = st_gnt;
            addr_d  = st_gnt ? st_addr_i : ld_addr_i;
            wdata_d = st_gnt ? st_data_i : '0;
            be_d    = st_gnt ? st_be_i : '1;
            tid_d   = st_gnt ? '0 : free_id;
        end else if (mem_gnt_i) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_busy_q <= '0;
            st_cnt_q  <= '0;
            starve_q  <= '0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            tid_q     <= '0;
        end else begin
            id_busy_q <= id_busy_d;
            st_cnt_q  <= st_cnt_d;
            starve_q  <= starve_d;
            err_q     <= err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            tid_q     <= tid_d;
        end
    end

    assign ld_gnt_o         = ld_gnt;
    assign st_gnt_o         = st_gnt;
    assign ld_tid_o         = ld_gnt ? free_id : '0;
    assign mem_req_o        = req_q;
    assign mem_we_o         = we_q;
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_be_o         = be_q;
    assign mem_tid_o        = tid_q;
    assign st_outstanding_o = st_cnt_q;
    assign idle_o           = (st_cnt_q == '0) && (id_busy_q == '0) && !req_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_dcache_mem_req_sched.sv
// Randomized and directed bench for dcache_mem_req_sched: a transaction-level model predicts grants,
// pushes expected memory requests into a scoreboard, and a monitor checks them at the memory handshake.
module tb_dcache_mem_req_sched;

    localparam int NIDS   = 2;
    localparam int MAXST  = 7;
    localparam int STARVE = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ld_req_i, ld_gnt_o, ld_nc_i;
    logic [31:0] ld_addr_i;
    logic [0:0]  ld_tid_o;
    logic        st_req_i, st_gnt_o;
    logic [31:0] st_addr_i, st_data_i;
    logic [3:0]  st_be_i;
    logic        mem_req_o, mem_gnt_i, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [0:0]  mem_tid_o;
    logic        mem_rsp_valid_i, mem_rsp_we_i;
    logic [0:0]  mem_rsp_tid_i;
    logic [2:0]  st_outstanding_o;
    logic        idle_o, err_o;

    dcache_mem_req_sched #(
        .AddrWidth(32), .DataWidth(32), .NrLoadIds(NIDS),
        .MaxOutstandingStores(MAXST), .StarveLimit(STARVE)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ld_req_i(ld_req_i), .ld_gnt_o(ld_gnt_o), .ld_addr_i(ld_addr_i),
        .ld_nc_i(ld_nc_i), .ld_tid_o(ld_tid_o),
        .st_req_i(st_req_i), .st_gnt_o(st_gnt_o), .st_addr_i(st_addr_i),
        .st_data_i(st_data_i), .st_be_i(st_be_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_tid_o(mem_tid_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_we_i(mem_rsp_we_i), .mem_rsp_tid_i(mem_rsp_tid_i),
        .st_outstanding_o(st_outstanding_o), .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [0:0]  tid;
    } txn_t;

    txn_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state: outstanding stores, allocated IDs, lost-arbitration streak, sticky error.
    int   m_st;
    bit   m_alloc[NIDS];
    int   m_starve;
    bit   m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk_i) begin : monitor
        txn_t t;
        #2;
        if (rst_ni && mem_req_o && mem_gnt_i) begin
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL mem_unexpected: got request addr %0h expected none at %0t", mem_addr_o, $time);
            end else begin
                t = sbq.pop_front();
                chk("mem_we",    64'(mem_we_o),    64'(t.we));
                chk("mem_addr",  64'(mem_addr_o),  64'(t.addr));
                chk("mem_wdata", 64'(mem_wdata_o), 64'(t.wdata));
                chk("mem_be",    64'(mem_be_o),    64'(t.be));
                chk("mem_tid",   64'(mem_tid_o),   64'(t.tid));
            end
        end
    end

    task automatic model_clear();
        m_st = 0;
        m_starve = 0;
        m_err = 0;
        foreach (m_alloc[i]) m_alloc[i] = 0;
        sbq.delete();
    endtask

    task automatic cyc(input bit ld, input bit nc, input bit st, input bit gnt,
                       input bit rv, input bit rwe, input int rtid, input logic [31:0] la);
        int   fid;
        bit   any_alloc, pend_st, ld_ok, st_ok, can, e_ld, e_st;
        txn_t t;
        @(negedge clk_i);
        ld_req_i        = ld;
        ld_nc_i         = nc;
        ld_addr_i       = la;
        st_req_i        = st;
        st_addr_i       = $urandom();
        st_data_i       = $urandom();
        st_be_i         = 4'($urandom());
        mem_gnt_i       = gnt;
        mem_rsp_valid_i = rv;
        mem_rsp_we_i    = rwe;
        mem_rsp_tid_i   = 1'(rtid);
        #1;
        fid = -1;
        any_alloc = 0;
        for (int i = NIDS - 1; i >= 0; i--) begin
            if (!m_alloc[i]) fid = i;
            else any_alloc = 1;
        end
        pend_st = (sbq.size() > 0) && sbq[0].we;
        ld_ok = ld && (fid >= 0) && (!nc || (m_st == 0 && !pend_st));
        st_ok = st && (m_st < MAXST);
        can   = (sbq.size() == 0) || gnt;
        e_st  = can && st_ok && (!ld_ok || m_starve == STARVE);
        e_ld  = can && ld_ok && !e_st;

        chk("ld_gnt", 64'(ld_gnt_o), 64'(e_ld));
        chk("st_gnt", 64'(st_gnt_o), 64'(e_st));
        if (e_ld) chk("ld_tid", 64'(ld_tid_o), 64'(fid));
        chk("mem_req", 64'(mem_req_o), 64'(sbq.size() > 0));
        chk("st_outstanding", 64'(st_outstanding_o), 64'(m_st));
        chk("idle", 64'(idle_o), 64'(m_st == 0 && !any_alloc && sbq.size() == 0));
        chk("err", 64'(err_o), 64'(m_err));

        if (e_ld) begin
            t.we = 0; t.addr = la; t.wdata = 32'h0; t.be = 4'hf; t.tid = 1'(fid);
            sbq.push_back(t);
        end
        if (e_st) begin
            t.we = 1; t.addr = st_addr_i; t.wdata = st_data_i; t.be = st_be_i; t.tid = 1'b0;
            sbq.push_back(t);
        end

        @(posedge clk_i);
        if (rv && rwe) begin
            if (m_st > 0) m_st--;
            else m_err = 1;
        end
        if (e_st) m_st++;
        if (rv && !rwe) begin
            if (m_alloc[rtid]) m_alloc[rtid] = 0;
            else m_err = 1;
        end
        if (e_ld) m_alloc[fid] = 1;
        if (e_st) m_starve = 0;
        else if (st_ok && e_ld && m_starve < STARVE) m_starve++;
    endtask

    // Responder: return the lowest allocated load ID, otherwise ack a store.
    task automatic acyc(input bit ld, input bit nc, input bit st, input bit gnt);
        int a = -1;
        for (int i = NIDS - 1; i >= 0; i--) if (m_alloc[i]) a = i;
        if (a >= 0)       cyc(ld, nc, st, gnt, 1, 0, a, $urandom());
        else if (m_st > 0) cyc(ld, nc, st, gnt, 1, 1, 0, $urandom());
        else              cyc(ld, nc, st, gnt, 0, 0, 0, $urandom());
    endtask

    task automatic rcyc();
        bit ld, nc, st, gnt, rv, rwe;
        int rt, pick;
        ld  = ($urandom_range(3) != 0);
        nc  = ($urandom_range(7) == 0);
        st  = $urandom_range(1) == 1;
        gnt = ($urandom_range(3) != 0);
        rv  = 0; rwe = 0; rt = 0;
        if ($urandom_range(1) == 1) begin
            pick = $urandom_range(NIDS - 1);
            if (m_st > 0 && $urandom_range(1) == 1) begin
                rv = 1; rwe = 1;
            end else if (m_alloc[pick]) begin
                rv = 1; rt = pick;
            end else if (m_st > 0) begin
                rv = 1; rwe = 1;
            end
        end
        cyc(ld, nc, st, gnt, rv, rwe, rt, $urandom());
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) acyc(0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 0;
        ld_req_i = 0; ld_nc_i = 0; st_req_i = 0; mem_gnt_i = 0;
        mem_rsp_valid_i = 0; mem_rsp_we_i = 0; mem_rsp_tid_i = '0;
        @(posedge clk_i);
        #1;
        model_clear();
        chk("rst_mem_req", 64'(mem_req_o), 64'(0));
        chk("rst_mem_be", 64'(mem_be_o), 64'(0));
        chk("rst_st_outstanding", 64'(st_outstanding_o), 64'(0));
        chk("rst_idle", 64'(idle_o), 64'(1));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_gnt", 64'({ld_gnt_o, st_gnt_o}), 64'(0));
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    initial begin
        rst_ni = 0;
        ld_req_i = 0; ld_nc_i = 0; ld_addr_i = '0;
        st_req_i = 0; st_addr_i = '0; st_data_i = '0; st_be_i = '0;
        mem_gnt_i = 0; mem_rsp_valid_i = 0; mem_rsp_we_i = 0; mem_rsp_tid_i = '0;
        model_clear();
        do_reset();

        // single load, then its response returns the block to idle
        cyc(1, 0, 0, 1, 0, 0, 0, 32'h8000_0010);
        cyc(0, 0, 0, 1, 0, 0, 0, $urandom());
        cyc(0, 0, 0, 1, 1, 0, 0, $urandom());
        cyc(0, 0, 0, 1, 0, 0, 0, $urandom());

        // store credit exhaustion, release by ack, ack and grant together
        repeat (8) cyc(0, 0, 1, 1, 0, 0, 0, $urandom());
        cyc(0, 0, 1, 1, 1, 1, 0, $urandom());
        cyc(0, 0, 1, 1, 0, 0, 0, $urandom());
        cyc(0, 0, 1, 1, 1, 1, 0, $urandom());
        cyc(0, 0, 1, 1, 1, 1, 0, $urandom());
        drain();

        // ID pool exhaustion and reuse of the freed ID
        repeat (3) cyc(1, 0, 0, 1, 0, 0, 0, $urandom());
        cyc(1, 0, 0, 1, 1, 0, 1, $urandom());
        cyc(1, 0, 0, 1, 0, 0, 0, $urandom());
        drain();

        // non-cacheable load waits for store drain; cacheable load does not
        repeat (2) cyc(0, 0, 1, 1, 0, 0, 0, $urandom());
        repeat (3) cyc(1, 1, 0, 1, 0, 0, 0, $urandom());
        repeat (2) cyc(1, 1, 0, 1, 1, 1, 0, $urandom());
        repeat (2) cyc(1, 1, 0, 1, 0, 0, 0, $urandom());
        drain();
        repeat (2) cyc(0, 0, 1, 1, 0, 0, 0, $urandom());
        cyc(1, 0, 0, 1, 0, 0, 0, $urandom());
        drain();

        // starvation rotation, then memory back-pressure
        repeat (30) acyc(1, 0, 1, 1);
        repeat (3) acyc(1, 0, 1, 0);
        repeat (10) acyc(1, 0, 1, 1);
        drain();

        repeat (3000) rcyc();
        drain();

        // protocol errors and reset recovery
        do_reset();
        cyc(0, 0, 0, 1, 1, 0, 1, $urandom());
        repeat (3) cyc(0, 0, 0, 1, 0, 0, 0, $urandom());
        cyc(0, 0, 0, 1, 1, 1, 0, $urandom());
        repeat (3) cyc(0, 0, 1, 1, 0, 0, 0, $urandom());
        cyc(0, 0, 0, 1, 0, 0, 0, $urandom());
        do_reset();
        repeat (3) cyc(0, 0, 0, 1, 0, 0, 0, $urandom());
        cyc(0, 0, 0, 1, 1, 0, 0, $urandom());
        cyc(0, 0, 0, 1, 0, 0, 0, $urandom());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
